// File: rtl/vga_hvsync_gen.sv
// Free-running VGA raster timing generator (640x480@60 by default).
// Provides pixel/line counters, registered syncs, display enable and end-of-line/frame strobes.
module vga_hvsync_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_end,
    output logic       frame_end
);

    localparam logic [9:0] H_LAST       = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST       = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;
    logic [9:0] w_hpos_nxt;
    logic [9:0] w_vpos_nxt;
    logic       w_line_end;
    logic       w_frame_end;
    logic       w_hsync_nxt;
    logic       w_vsync_nxt;

    always_comb begin
        w_line_end  = (r_hpos == H_LAST);
        w_frame_end = w_line_end && (r_vpos == V_LAST);
        w_hpos_nxt  = w_line_end ? 10'd0 : r_hpos + 10'd1;
        w_vpos_nxt  = r_vpos;
        if (w_frame_end) begin
            w_vpos_nxt = 10'd0;
        end else if (w_line_end) begin
            w_vpos_nxt = r_vpos + 10'd1;
        end
        // Syncs decode the next counter values so the registered pulses line up with hpos/vpos.
        w_hsync_nxt = ((w_hpos_nxt >= H_SYNC_START) && (w_hpos_nxt <= H_SYNC_END)) ?
                      SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_vsync_nxt = ((w_vpos_nxt >= V_SYNC_START) && (w_vpos_nxt <= V_SYNC_END)) ?
                      SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hpos  <= 10'd0;
            r_vpos  <= 10'd0;
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
        end else begin
            r_hpos  <= w_hpos_nxt;
            r_vpos  <= w_vpos_nxt;
            r_hsync <= w_hsync_nxt;
            r_vsync <= w_vsync_nxt;
        end
    end

    assign hpos       = r_hpos;
    assign vpos       = r_vpos;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign line_end   = w_line_end;
    assign frame_end  = w_frame_end;
    assign display_on = (r_hpos < H_VIS) && (r_vpos < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Bench for vga_hvsync_gen: a full-size instance plus a shrunken-timing instance so whole frames fit in a short run.
// Both share one reset, so a single "clocks since reset" count drives the arithmetic reference model.
module tb_vga_hvsync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       a_hs, a_vs, a_de, a_le, a_fe;
    logic [9:0] a_hpos, a_vpos;
    logic       b_hs, b_vs, b_de, b_le, b_fe;
    logic [9:0] b_hpos, b_vpos;

    vga_hvsync_gen u_dflt (
        .clk(clk), .rst_n(rst_n), .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
        .hpos(a_hpos), .vpos(a_vpos), .line_end(a_le), .frame_end(a_fe)
    );

    vga_hvsync_gen #(
        .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4), .SYNC_ACTIVE(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
        .hpos(b_hpos), .vpos(b_vpos), .line_end(b_le), .frame_end(b_fe)
    );

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hs;
        logic       vs;
        logic       de;
        logic       le;
        logic       fe;
    } obs_t;

    typedef struct {
        logic rst_n;
        int   cycles;
        obs_t exp;
    } vec_t;

    int t = 0;
    int vectors = 0;
    int miscompares = 0;

    function automatic obs_t model(int tt, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb);
        obs_t o;
        int ht, vt, h, v;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        h  = tt % ht;
        v  = (tt / ht) % vt;
        o.hpos = 10'(h);
        o.vpos = 10'(v);
        o.hs   = !((h >= hd + hf) && (h < hd + hf + hs));
        o.vs   = !((v >= vd + vf) && (v < vd + vf + vs));
        o.de   = (h < hd) && (v < vd);
        o.le   = (h == ht - 1);
        o.fe   = (h == ht - 1) && (v == vt - 1);
        return o;
    endfunction

    function automatic obs_t mk(int h, int v, logic hs, logic vs, logic de, logic le, logic fe);
        obs_t o;
        o.hpos = 10'(h);
        o.vpos = 10'(v);
        o.hs = hs; o.vs = vs; o.de = de; o.le = le; o.fe = fe;
        return o;
    endfunction

    function automatic obs_t obs_a();
        return {a_hpos, a_vpos, a_hs, a_vs, a_de, a_le, a_fe};
    endfunction

    function automatic obs_t obs_b();
        return {b_hpos, b_vpos, b_hs, b_vs, b_de, b_le, b_fe};
    endfunction

    task automatic summary_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b le=%b fe=%b want h=%0d v=%0d hs=%b vs=%b de=%b le=%b fe=%b",
                     name, t, act.hpos, act.vpos, act.hs, act.vs, act.de, act.le, act.fe,
                     exp.hpos, exp.vpos, exp.hs, exp.vs, exp.de, exp.le, exp.fe);
            if (miscompares >= 200) summary_and_finish();
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r);
        rst_n = r;
        @(posedge clk);
        if (!r) t = 0;
        else    t++;
        #1;
        check("dflt_model", obs_a(), model(t, 640, 16, 96, 48, 480, 10, 2, 33));
        check("small_model", obs_b(), model(t, 64, 4, 8, 4, 12, 3, 2, 4));
    endtask

    vec_t tbl[12];
    int   vs_low, de_high, le_cnt, fe_cnt, last_origin, origins, found;

    initial begin
        tbl[0]  = '{rst_n: 1'b0, cycles: 3,  exp: mk(0,   0, 1, 1, 1, 0, 0)};
        tbl[1]  = '{rst_n: 1'b1, cycles: 1,  exp: mk(1,   0, 1, 1, 1, 0, 0)};
        tbl[2]  = '{rst_n: 1'b1, cycles: 638, exp: mk(639, 0, 1, 1, 1, 0, 0)};
        tbl[3]  = '{rst_n: 1'b1, cycles: 1,  exp: mk(640, 0, 1, 1, 0, 0, 0)};
        tbl[4]  = '{rst_n: 1'b1, cycles: 15, exp: mk(655, 0, 1, 1, 0, 0, 0)};
        tbl[5]  = '{rst_n: 1'b1, cycles: 1,  exp: mk(656, 0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{rst_n: 1'b1, cycles: 95, exp: mk(751, 0, 0, 1, 0, 0, 0)};
        tbl[7]  = '{rst_n: 1'b1, cycles: 1,  exp: mk(752, 0, 1, 1, 0, 0, 0)};
        tbl[8]  = '{rst_n: 1'b1, cycles: 47, exp: mk(799, 0, 1, 1, 0, 1, 0)};
        tbl[9]  = '{rst_n: 1'b1, cycles: 1,  exp: mk(0,   1, 1, 1, 1, 0, 0)};
        tbl[10] = '{rst_n: 1'b1, cycles: 300, exp: mk(300, 1, 1, 1, 1, 0, 0)};
        tbl[11] = '{rst_n: 1'b0, cycles: 1,  exp: mk(0,   0, 1, 1, 1, 0, 0)};

        for (int i = 0; i < 12; i++) begin
            repeat (tbl[i].cycles) step(tbl[i].rst_n);
            check($sformatf("tbl%0d", i), obs_a(), tbl[i].exp);
        end

        // Two full frames of the shrunken instance: 80 clocks/line, 21 lines, 1680 clocks/frame.
        vs_low = 0; de_high = 0; le_cnt = 0; fe_cnt = 0; origins = 0; last_origin = 0;
        step(1'b0);
        for (int i = 0; i < 2 * 1680; i++) begin
            if (t < 1680) begin
                if (b_vs == 1'b0) vs_low++;
                if (b_de) de_high++;
                if (b_le) le_cnt++;
            end
            if (b_fe) begin
                fe_cnt++;
                check_int("fe_pos_h", int'(b_hpos), 79);
                check_int("fe_pos_v", int'(b_vpos), 20);
            end
            if (b_hpos == 10'd0 && b_vpos == 10'd0) begin
                if (origins > 0) check_int("frame_period", t - last_origin, 1680);
                last_origin = t;
                origins++;
            end
            step(1'b1);
        end
        check_int("vsync_low_clocks", vs_low, 160);
        check_int("display_on_clocks", de_high, 768);
        check_int("line_end_pulses", le_cnt, 21);
        check_int("frame_end_pulses", fe_cnt, 2);
        check_int("origin_count", origins, 2);
        check_int("origin_after_frames", int'({b_hpos, b_vpos}), 0);

        // Mid-frame reset at (30,10) of the small instance.
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            if (b_hpos == 10'd30 && b_vpos == 10'd10) found = 1;
            else step(1'b1);
        end
        check_int("reach_30_10", found, 1);
        step(1'b0);
        check_int("midrst_hpos", int'(b_hpos), 0);
        check_int("midrst_vpos", int'(b_vpos), 0);
        check_int("midrst_hsync", int'(b_hs), 1);
        check_int("midrst_vsync", int'(b_vs), 1);
        repeat (200) step(1'b1);

        // Long uninterrupted run on the full-size instance, then random resets.
        step(1'b0);
        repeat (30000) step(1'b1);
        repeat (15000) step($urandom_range(0, 2999) != 0);

        summary_and_finish();
    end

endmodule
